// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned DEFAULT_CNT_W = 32;
  localparam int unsigned DEFAULT_HALF  = 50_000_000;
  localparam int unsigned CLK_HZ        = 100_000_000;

  // Half-period in board-clock cycles for a requested output frequency.
  function automatic int unsigned half_for_hz(input int unsigned hz);
    return CLK_HZ / (2 * hz);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, 50% duty output, rising-edge tick and a
// staged half-period that is swapped in only at a toggle boundary.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W      = DEFAULT_CNT_W,
  parameter int unsigned RESET_HALF = DEFAULT_HALF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_half,
  output logic             div_clk,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] staged_q, staged_d;
  logic [CNT_W-1:0] eff_half;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             at_edge;

  // A stored half of zero would never toggle, so it runs as one.
  assign eff_half = (half_q == '0) ? CNT_W'(1) : half_q;
  assign at_edge  = (cnt_q == eff_half - CNT_W'(1));

  always_comb begin
    cnt_d    = cnt_q;
    half_d   = half_q;
    staged_d = staged_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    pend_d   = pend_q;
    if (!en) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_q) begin
        half_d = staged_q;
        pend_d = 1'b0;
      end
    end else if (at_edge) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = ~clk_q;
      if (pend_q) begin
        half_d = staged_q;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Loads arrive only while nothing is pending, so they never race the apply above.
    if (load) begin
      staged_d = load_half;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      half_q   <= CNT_W'(RESET_HALF);
      staged_q <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      staged_q <= staged_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
    end
  end

  assign div_clk = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: load decode, ready mux and channel array.
module clk_div_multi #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = clk_div_pkg::DEFAULT_CNT_W,
  parameter int unsigned DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_load_valid,
  input  logic [CH_W-1:0]   i_load_ch,
  input  logic [CNT_W-1:0]  i_load_half,
  output logic              o_load_ready,
  output logic [NUM_CH-1:0] o_clk,
  output logic [NUM_CH-1:0] o_tick
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] load;

  // Out-of-range channels report ready and are silently dropped.
  always_comb begin
    o_load_ready = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (i_load_ch == CH_W'(i)) o_load_ready = ~pending[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign load[g] = i_load_valid && o_load_ready && (i_load_ch == CH_W'(g));

    clk_div_channel #(
      .CNT_W      (CNT_W),
      .RESET_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk       (i_clk),
      .rst       (i_reset),
      .en        (i_en[g]),
      .load      (load[g]),
      .load_half (i_load_half),
      .div_clk   (o_clk[g]),
      .tick      (o_tick[g]),
      .pending   (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi (2 channels, 8-bit counters, reset half of 3).
module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [1:0] i_en;
  logic       i_load_valid;
  logic       i_load_ch;
  logic [7:0] i_load_half;
  logic       o_load_ready;
  logic [1:0] o_clk;
  logic [1:0] o_tick;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NUM_CH       (2),
    .CNT_W        (8),
    .DEFAULT_HALF (3)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_en         (i_en),
    .i_load_valid (i_load_valid),
    .i_load_ch    (i_load_ch),
    .i_load_half  (i_load_half),
    .o_load_ready (o_load_ready),
    .o_clk        (o_clk),
    .o_tick       (o_tick)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: countdown of cycles left in the current phase.
  logic [7:0] m_half[2];
  logic [7:0] m_stg[2];
  int         m_rem[2];
  logic [1:0] m_pend, m_clk, m_tick;
  logic [3:0] sb_q[$];
  logic       last_acc;
  int         cyc;
  int         last_tick[2];
  int         per[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input logic [7:0] h);
    return (h == 8'd0) ? 1 : int'(h);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_half[c] = 8'd3;
      m_stg[c]  = 8'd0;
      m_rem[c]  = 3;
      last_tick[c] = -1;
      per[c] = 0;
    end
    m_pend = '0;
    m_clk  = '0;
    m_tick = '0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic [1:0] en, input logic acc, input logic ach,
                            input logic [7:0] ah);
    for (int c = 0; c < 2; c++) begin
      if (!en[c]) begin
        if (m_pend[c]) begin
          m_half[c] = m_stg[c];
          m_pend[c] = 1'b0;
        end
        m_clk[c]  = 1'b0;
        m_tick[c] = 1'b0;
        m_rem[c]  = eff(m_half[c]);
      end else if (m_rem[c] == 1) begin
        m_clk[c]  = ~m_clk[c];
        m_tick[c] = m_clk[c];
        if (m_pend[c]) begin
          m_half[c] = m_stg[c];
          m_pend[c] = 1'b0;
        end
        m_rem[c] = eff(m_half[c]);
      end else begin
        m_rem[c]  = m_rem[c] - 1;
        m_tick[c] = 1'b0;
      end
      if (acc && (int'(ach) == c)) begin
        m_stg[c]  = ah;
        m_pend[c] = 1'b1;
      end
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare the registered result.
  task automatic step(input logic [1:0] en, input logic lv, input logic lch,
                      input logic [7:0] lh);
    logic       acc;
    logic [3:0] exp;
    i_en = en;
    i_load_valid = lv;
    i_load_ch = lch;
    i_load_half = lh;
    #1;
    check_eq("ready", {31'd0, o_load_ready}, {31'd0, ~m_pend[lch]});
    acc = lv && !m_pend[lch];
    last_acc = acc;
    model_step(en, acc, lch, lh);
    sb_q.push_back({m_clk, m_tick});
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check_eq("clk", {30'd0, o_clk}, {30'd0, exp[3:2]});
    check_eq("tick", {30'd0, o_tick}, {30'd0, exp[1:0]});
    cyc++;
    for (int c = 0; c < 2; c++) begin
      if (o_tick[c]) begin
        if (last_tick[c] >= 0) per[c] = cyc - last_tick[c];
        last_tick[c] = cyc;
      end
    end
  endtask

  task automatic idle(input logic [1:0] en, input int n);
    for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0, 8'd0);
  endtask

  int n;

  initial begin
    cyc = 0;
    i_reset = 1'b1;
    i_en = 2'b00;
    i_load_valid = 1'b0;
    i_load_ch = 1'b0;
    i_load_half = 8'd0;
    model_reset();
    #12;
    check_eq("rst_clk", {30'd0, o_clk}, 32'd0);
    check_eq("rst_tick", {30'd0, o_tick}, 32'd0);
    check_eq("rst_ready", {31'd0, o_load_ready}, 32'd1);
    @(posedge clk);
    #1;
    i_reset = 1'b0;

    // Reset release with ch0 enabled: period 6.
    idle(2'b01, 14);
    check_eq("s1_per0", per[0], 32'd6);

    // Disable while high, then re-enable: first rise 3 cycles later.
    n = 0;
    while (!o_clk[0] && n < 20) begin
      step(2'b01, 1'b0, 1'b0, 8'd0);
      n++;
    end
    check_eq("s5_high", {31'd0, o_clk[0]}, 32'd1);
    idle(2'b00, 6);
    n = 0;
    do begin
      step(2'b01, 1'b0, 1'b0, 8'd0);
      n++;
    end while (!o_clk[0] && n < 20);
    check_eq("s5_rise", n, 32'd3);
    check_eq("s5_tick", {31'd0, o_tick[0]}, 32'd1);

    // Load ch0 half=1 in the 2nd cycle of a high phase.
    idle(2'b01, 1);
    step(2'b01, 1'b1, 1'b0, 8'd1);
    idle(2'b01, 10);
    check_eq("s2_per0", per[0], 32'd2);

    // ch1 half=0 while disabled, then enable: toggles every cycle.
    step(2'b01, 1'b1, 1'b1, 8'd0);
    idle(2'b01, 2);
    idle(2'b11, 8);
    check_eq("s3_per1", per[1], 32'd2);

    // Back-to-back ch0 loads with a ch1 load slipped in between.
    step(2'b11, 1'b1, 1'b0, 8'd5);
    step(2'b11, 1'b1, 1'b1, 8'd2);
    n = 0;
    do begin
      step(2'b11, 1'b1, 1'b0, 8'd7);
      n++;
    end while (!last_acc && n < 30);
    check_eq("s4_acc", {31'd0, last_acc}, 32'd1);
    idle(2'b11, 40);
    check_eq("s4_per0", per[0], 32'd14);
    check_eq("s4_per1", per[1], 32'd4);

    // Async reset mid-phase with a pending load.
    step(2'b01, 1'b1, 1'b0, 8'd2);
    idle(2'b01, 1);
    #1;
    i_reset = 1'b1;
    #1;
    check_eq("s6_clk", {30'd0, o_clk}, 32'd0);
    check_eq("s6_tick", {30'd0, o_tick}, 32'd0);
    check_eq("s6_ready", {31'd0, o_load_ready}, 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    idle(2'b01, 20);
    check_eq("s6_per0", per[0], 32'd6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
